// File: rtl/nios2_debug_ocimem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nios2_debug_ocimem_ctrl
// Purpose  : Turns decoded JTAG debug commands into Avalon-style address-load,
//            write and read transactions on the CPU's on-chip debug memory.
// Revision : 1.0
// ============================================================================
module nios2_debug_ocimem_ctrl #(
    parameter int ADDR_W       = 8,
    parameter int READ_LATENCY = 1,
    parameter int TIMEOUT      = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    input  logic [31:0]       mem_readdata,
    input  logic              mem_waitrequest,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    localparam logic [15:0] c_tmo_last = 16'(TIMEOUT - 1);
    localparam logic [2:0]  c_rd_lat   = 3'(READ_LATENCY);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_REQ  = 2'd1,
        S_RD_WAIT = 2'd2,
        S_WR_REQ  = 2'd3
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [31:0]       r_wdata, w_wdata_nxt;
    logic [31:0]       r_mon, w_mon_nxt;
    logic              r_ready, w_ready_nxt;
    logic              r_error, w_error_nxt;
    logic [15:0]       r_tmo, w_tmo_nxt;
    logic [2:0]        r_lat, w_lat_nxt;
    logic              w_strobe_any;
    logic              w_unused;

    assign w_strobe_any = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign w_unused     = ^jdo[37:35];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_mon   <= '0;
            r_ready <= 1'b1;
            r_error <= 1'b0;
            r_tmo   <= '0;
            r_lat   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_mon   <= w_mon_nxt;
            r_ready <= w_ready_nxt;
            r_error <= w_error_nxt;
            r_tmo   <= w_tmo_nxt;
            r_lat   <= w_lat_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_mon_nxt   = r_mon;
        w_ready_nxt = r_ready;
        w_error_nxt = r_error;
        w_tmo_nxt   = r_tmo;
        w_lat_nxt   = r_lat;

        // Busy: strobes are dropped as overruns, except an error-clear request
        if (r_state != S_IDLE) begin
            if (take_action_ocimem_a && jdo[0]) begin
                w_error_nxt = 1'b0;
            end else if (w_strobe_any) begin
                w_error_nxt = 1'b1;
            end
        end

        case (r_state)
            S_IDLE: begin
                if (take_action_ocimem_a) begin
                    w_addr_nxt = jdo[ADDR_W+1:2];
                    if (jdo[0]) begin
                        w_error_nxt = 1'b0;
                    end
                    if (jdo[1]) begin
                        w_ready_nxt = 1'b0;
                        w_state_nxt = S_RD_REQ;
                    end
                end else if (take_action_ocimem_b) begin
                    w_wdata_nxt = jdo[34:3];
                    w_ready_nxt = 1'b0;
                    w_state_nxt = S_WR_REQ;
                end else if (take_no_action_ocimem_a) begin
                    w_ready_nxt = 1'b0;
                    w_state_nxt = S_RD_REQ;
                end
            end
            S_RD_REQ, S_WR_REQ: begin
                if (mem_waitrequest) begin
                    if (r_tmo == c_tmo_last) begin
                        // Abandon the stalled request; address and read data are kept
                        w_tmo_nxt   = '0;
                        w_error_nxt = 1'b1;
                        w_ready_nxt = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_tmo_nxt = r_tmo + 16'd1;
                    end
                end else begin
                    w_tmo_nxt  = '0;
                    w_addr_nxt = r_addr + ADDR_W'(1);
                    if (r_state == S_WR_REQ) begin
                        w_ready_nxt = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_lat_nxt   = c_rd_lat;
                        w_state_nxt = S_RD_WAIT;
                    end
                end
            end
            S_RD_WAIT: begin
                w_lat_nxt = r_lat - 3'd1;
                if (r_lat <= 3'd1) begin
                    w_mon_nxt   = mem_readdata;
                    w_ready_nxt = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign mem_read      = (r_state == S_RD_REQ);
    assign mem_write     = (r_state == S_WR_REQ);
    assign mem_address   = r_addr;
    assign mem_writedata = r_wdata;
    assign MonDReg       = r_mon;
    assign monitor_ready = r_ready;
    assign monitor_error = r_error;

endmodule
`default_nettype wire

// File: tb/tb_nios2_debug_ocimem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_nios2_debug_ocimem_ctrl
// Purpose  : Scoreboard bench for the OCI debug-memory controller with a
//            stalling memory slave and a command-level reference model.
// Revision : 1.0
// ============================================================================
module tb_nios2_debug_ocimem_ctrl;

    localparam int ADDR_W       = 8;
    localparam int READ_LATENCY = 1;
    localparam int TIMEOUT      = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [37:0] jdo = '0;
    logic        ta_a = 1'b0, ta_b = 1'b0, tna_a = 1'b0;
    logic [7:0]  mem_address;
    logic        mem_read, mem_write;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata = '0;
    logic        mem_waitrequest = 1'b0;
    logic [31:0] MonDReg;
    logic        monitor_ready, monitor_error;

    always #5 clk = ~clk;

    nios2_debug_ocimem_ctrl #(
        .ADDR_W(ADDR_W), .READ_LATENCY(READ_LATENCY), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .jdo(jdo),
        .take_action_ocimem_a(ta_a), .take_action_ocimem_b(ta_b),
        .take_no_action_ocimem_a(tna_a),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
        .mem_waitrequest(mem_waitrequest), .MonDReg(MonDReg),
        .monitor_ready(monitor_ready), .monitor_error(monitor_error)
    );

    typedef struct { bit wr; logic [7:0] addr; logic [31:0] data; } bus_t;
    typedef struct { logic [31:0] mon; logic err; } done_t;

    int          n_tests = 0, n_fail = 0;
    bus_t        exp_bus[$];
    done_t       exp_done[$];
    logic [31:0] ref_mem [256];
    logic [31:0] slave_mem [256];
    logic [7:0]  m_addr = '0;
    logic [31:0] m_mon = '0;
    logic        m_err = 1'b0;
    int          stall_target = 0, stall_cnt = 0;
    bit          rst_seen = 1'b0;
    logic        prev_ready = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [37:0] wr_jdo(input logic [31:0] d);
        return {3'b000, d, 3'b000};
    endfunction

    function automatic logic [37:0] ad_jdo(input logic [7:0] a, input logic rd, input logic clr);
        return {28'd0, a, rd, clr};
    endfunction

    // kind: 0 = addr/ctrl, 1 = write, 2 = read, 3 = all three strobes, other = none
    task automatic drive(input int k, input logic [37:0] j);
        jdo   = j;
        ta_a  = (k == 0 || k == 3);
        ta_b  = (k == 1 || k == 3);
        tna_a = (k == 2 || k == 3);
    endtask

    // Memory slave: programmable stall count per request, fixed read latency 1
    initial begin : slave
        bit          acc_rd, acc_wr;
        logic [7:0]  a;
        logic [31:0] d;
        forever begin
            @(negedge clk);
            acc_rd = mem_read && !mem_waitrequest;
            acc_wr = mem_write && !mem_waitrequest;
            a = mem_address;
            d = mem_writedata;
            @(posedge clk);
            #1;
            if (acc_wr) slave_mem[a] = d;
            mem_readdata = acc_rd ? slave_mem[a] : $urandom;
            #1;
            if (mem_read || mem_write) begin
                if (stall_cnt < stall_target) begin
                    mem_waitrequest = 1'b1;
                    stall_cnt++;
                end else begin
                    mem_waitrequest = 1'b0;
                end
            end else begin
                mem_waitrequest = 1'b0;
                stall_cnt = 0;
            end
        end
    end

    initial begin : monitor
        bus_t  eb;
        done_t ed;
        forever begin
            @(negedge clk);
            if (mem_read || mem_write)
                check("rd_wr_exclusive", 64'(mem_read & mem_write), 64'd0);
            if ((mem_read || mem_write) && !mem_waitrequest) begin
                if (exp_bus.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_accept: actual wr=%0b addr=0x%0h required none",
                             mem_write, mem_address);
                end else begin
                    eb = exp_bus.pop_front();
                    check("bus_kind", 64'(mem_write), 64'(eb.wr));
                    check("bus_addr", 64'(mem_address), 64'(eb.addr));
                    if (eb.wr) check("bus_wdata", 64'(mem_writedata), 64'(eb.data));
                end
            end
            if (rst_seen) begin
                rst_seen = 1'b0;
            end else if (monitor_ready && !prev_ready) begin
                if (exp_done.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done: actual MonDReg=0x%0h required none", MonDReg);
                end else begin
                    ed = exp_done.pop_front();
                    check("done_mondreg", 64'(MonDReg), 64'(ed.mon));
                    check("done_error", 64'(monitor_error), 64'(ed.err));
                end
            end
            prev_ready = monitor_ready;
        end
    end

    // Issue one command (optionally an overrun strobe ovc cycles later) and
    // follow it to completion, comparing timing and status to the model.
    task automatic run_cmd(input int k, input logic [37:0] j, input int stalls,
                           input int ovk, input logic [37:0] ovj, input int ovc_in);
        bit          busy, wr, tmo;
        int          busy_len, exp_req, done_cyc, req_cyc, bad, ovc;
        logic [7:0]  req_addr;
        logic [31:0] wd;
        busy = 1'b0; wr = 1'b0; wd = '0; ovc = ovc_in;
        if (k == 0 || k == 3) begin
            m_addr = j[9:2];
            if (j[0]) m_err = 1'b0;
            busy = j[1];
        end else if (k == 1) begin
            busy = 1'b1; wr = 1'b1; wd = j[34:3];
        end else begin
            busy = 1'b1;
        end
        req_addr = m_addr;
        tmo      = busy && (stalls >= TIMEOUT);
        busy_len = !busy ? 0 : (tmo ? TIMEOUT : stalls + (wr ? 1 : 2));
        exp_req  = !busy ? 0 : (tmo ? TIMEOUT : stalls + 1);
        if (!busy || ovk < 0) ovc = 0;
        if (ovc > busy_len) ovc = busy_len;
        if (ovc > 0) m_err = ((ovk == 0 || ovk == 3) && ovj[0]) ? 1'b0 : 1'b1;
        if (busy) begin
            if (tmo) begin
                m_err = 1'b1;
            end else begin
                exp_bus.push_back('{wr, m_addr, wd});
                if (wr) ref_mem[m_addr] = wd;
                else    m_mon = ref_mem[m_addr];
                m_addr = m_addr + 8'd1;
            end
            exp_done.push_back('{m_mon, m_err});
        end

        stall_target = stalls;
        @(posedge clk); #1;
        drive(k, j);
        done_cyc = -1; req_cyc = 0; bad = 0;
        for (int c = 1; c <= 80; c++) begin
            @(posedge clk); #1;
            drive(-1, j);
            if (c == ovc) drive(ovk, ovj);
            if (mem_read || mem_write) begin
                req_cyc++;
                if (mem_write !== wr || mem_address !== req_addr || (wr && mem_writedata !== wd))
                    bad++;
            end
            if (c > ovc && monitor_ready) begin
                done_cyc = c;
                break;
            end
        end
        check("done_cycle", 64'(done_cyc), 64'(busy_len + 1));
        check("req_cycles", 64'(req_cyc), 64'(exp_req));
        check("req_stable", 64'(bad), 64'd0);
        check("status_mondreg", 64'(MonDReg), 64'(m_mon));
        check("status_error", 64'(monitor_error), 64'(m_err));
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int          k, st, ovk, ovc;
        logic [37:0] j, ovj;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i]   = $urandom;
            slave_mem[i] = ref_mem[i];
        end
        ref_mem[8'h29]   = 32'hDEADBEEF;
        slave_mem[8'h29] = 32'hDEADBEEF;

        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_mem_read", 64'(mem_read), 64'd0);
        check("rst_mem_write", 64'(mem_write), 64'd0);
        check("rst_address", 64'(mem_address), 64'd0);
        check("rst_writedata", 64'(mem_writedata), 64'd0);
        check("rst_mondreg", 64'(MonDReg), 64'd0);
        check("rst_ready", 64'(monitor_ready), 64'd1);
        check("rst_error", 64'(monitor_error), 64'd0);

        // Address load with read at 0x29, then a stalled write landing at 0x2A
        run_cmd(0, 38'h00000000A6, 0, -1, '0, 0);
        run_cmd(1, wr_jdo(32'h12345678), 3, -1, '0, 0);
        // Wrap from 0xFF to 0x00
        run_cmd(0, ad_jdo(8'hFF, 1'b1, 1'b0), 0, -1, '0, 0);
        run_cmd(2, '0, 0, -1, '0, 0);
        // Stuck slave times out, then the error is cleared
        run_cmd(2, '0, 100, -1, '0, 0);
        run_cmd(0, ad_jdo(8'h40, 1'b0, 1'b1), 0, -1, '0, 0);
        // Read strobe during RD_WAIT, then all strobes in one idle cycle
        run_cmd(2, '0, 0, 2, '0, 2);
        run_cmd(3, ad_jdo(8'h10, 1'b0, 1'b0) | wr_jdo(32'hCAFEF00D), 0, -1, '0, 0);
        run_cmd(1, wr_jdo(32'hA5A55A5A), 0, -1, '0, 0);

        // Reset while a write is stalled on the bus
        stall_target = 100;
        @(posedge clk); #1;
        drive(1, wr_jdo(32'h0BADF00D));
        @(posedge clk); #1;
        drive(-1, '0);
        @(posedge clk); #2;
        rst_seen = 1'b1;
        reset    = 1'b1;
        #1;
        check("midrst_mem_write", 64'(mem_write), 64'd0);
        check("midrst_ready", 64'(monitor_ready), 64'd1);
        check("midrst_address", 64'(mem_address), 64'd0);
        m_addr = '0; m_mon = '0; m_err = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        run_cmd(1, wr_jdo(32'h5EED5EED), 0, -1, '0, 0);
        run_cmd(2, '0, 1, -1, '0, 0);

        for (int i = 0; i < 60; i++) begin
            k   = $urandom_range(0, 3);
            j   = 38'({$urandom, $urandom});
            st  = ($urandom_range(0, 7) == 0) ? $urandom_range(TIMEOUT, TIMEOUT + 2)
                                               : $urandom_range(0, 3);
            ovj = 38'({$urandom, $urandom});
            ovk = -1;
            ovc = 0;
            if ($urandom_range(0, 2) == 0) begin
                ovk = $urandom_range(0, 3);
                ovc = $urandom_range(1, 6);
            end
            run_cmd(k, j, st, ovk, ovj, ovc);
        end

        repeat (5) @(posedge clk);
        #1;
        check("bus_queue_empty", 64'(exp_bus.size()), 64'd0);
        check("done_queue_empty", 64'(exp_done.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
